// File: rtl/pa_rvfpm_pkg.sv
// Shared types and default sizes for the RISC-V FPU model's XIF front end.
// Holds the issue-queue entry state encoding, the entry payload struct and
// the default queue depth used by fpu_issue_sched.
package pa_rvfpm;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned QUEUE_DEPTH = 4;

    // Lifecycle of one in-flight offloaded instruction.
    typedef enum logic [1:0] {
        ENTRY_EMPTY       = 2'd0,
        ENTRY_WAIT_COMMIT = 2'd1,
        ENTRY_COMMITTED   = 2'd2
    } entry_state_e;

    // Payload captured at issue; kill is set by the commit interface.
    typedef struct packed {
        logic [31:0]                instr;
        logic [X_ID_WIDTH-1:0]      id;
        logic [2:0][XLEN-1:0]       rs;
        logic                       kill;
    } entry_t;

endpackage

// File: rtl/fpu_issue_sched.sv
// In-order issue scheduler between the XIF issue/commit interfaces and the
// FPU model. Accepted issues are queued, wait for their commit (or kill),
// and leave strictly in order from the head.
// Ports:
//   ck, rst                 clock, synchronous active-high reset
//   fpu_ready               FPU can take new work (gates issue_ready)
//   issue_valid/ready/accept, issue_instr/id/rs   XIF issue handshake + payload
//   commit_valid/id/kill    XIF commit or kill of an in-flight ID
//   disp_valid/ready, disp_instr/id/rs            head entry handed to the FPU
//   occupancy               number of valid queue entries
module fpu_issue_sched #(
    parameter int unsigned X_ID_WIDTH  = pa_rvfpm::X_ID_WIDTH,
    parameter int unsigned XLEN        = pa_rvfpm::XLEN,
    parameter int unsigned QUEUE_DEPTH = pa_rvfpm::QUEUE_DEPTH
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic                          fpu_ready,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic                          issue_accept,
    input  logic [31:0]                   issue_instr,
    input  logic [X_ID_WIDTH-1:0]         issue_id,
    input  logic [2:0][XLEN-1:0]          issue_rs,
    input  logic                          commit_valid,
    input  logic [X_ID_WIDTH-1:0]         commit_id,
    input  logic                          commit_kill,
    output logic                          disp_valid,
    input  logic                          disp_ready,
    output logic [31:0]                   disp_instr,
    output logic [X_ID_WIDTH-1:0]         disp_id,
    output logic [2:0][XLEN-1:0]          disp_rs,
    output logic [$clog2(QUEUE_DEPTH):0]  occupancy
);
    import pa_rvfpm::*;

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_state_e       state_q [QUEUE_DEPTH];
    entry_t             entry_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               head_committed;
    logic               head_kill;
    logic               push;
    logic               pop;
    logic               push_commit;

    // Ready/valid decode from registered state only; no same-cycle pop bypass.
    assign head_committed = (state_q[head_q] == ENTRY_COMMITTED);
    assign head_kill      = entry_q[head_q].kill;
    assign issue_ready    = ~rst & fpu_ready & (cnt_q < CNT_W'(QUEUE_DEPTH));
    assign disp_valid     = ~rst & head_committed & ~head_kill;
    assign push           = issue_valid & issue_ready & issue_accept;
    // A killed head drains by itself without waiting for the consumer.
    assign pop            = ~rst & head_committed & (head_kill | disp_ready);
    assign push_commit    = commit_valid & (issue_id == commit_id);

    assign disp_instr = rst ? '0 : entry_q[head_q].instr;
    assign disp_id    = rst ? '0 : entry_q[head_q].id;
    assign disp_rs    = rst ? '0 : entry_q[head_q].rs;
    assign occupancy  = cnt_q;

    // Queue storage, commit matching and pointer/count bookkeeping.
    always_ff @(posedge ck) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                state_q[PTR_W'(i)]      <= ENTRY_EMPTY;
                entry_q[PTR_W'(i)].kill <= 1'b0;
            end
        end else begin
            // Only WAIT_COMMIT entries respond, so head (COMMITTED when
            // popping) and tail (EMPTY when pushing) are never touched here.
            if (commit_valid) begin
                for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                    if (state_q[PTR_W'(i)] == ENTRY_WAIT_COMMIT &&
                        entry_q[PTR_W'(i)].id == commit_id) begin
                        state_q[PTR_W'(i)]      <= ENTRY_COMMITTED;
                        entry_q[PTR_W'(i)].kill <= commit_kill;
                    end
                end
            end

            if (push) begin
                entry_q[tail_q].instr <= issue_instr;
                entry_q[tail_q].id    <= issue_id;
                entry_q[tail_q].rs    <= issue_rs;
                // A commit for the ID being pushed this cycle lands on it.
                if (push_commit) begin
                    state_q[tail_q]      <= ENTRY_COMMITTED;
                    entry_q[tail_q].kill <= commit_kill;
                end else begin
                    state_q[tail_q]      <= ENTRY_WAIT_COMMIT;
                    entry_q[tail_q].kill <= 1'b0;
                end
                tail_q <= tail_q + PTR_W'(1);
            end

            if (pop) begin
                state_q[head_q] <= ENTRY_EMPTY;
                head_q          <= head_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Self-checking bench for fpu_issue_sched: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fpu_issue_sched;

    localparam int unsigned IDW   = 4;
    localparam int unsigned XL    = 32;
    localparam int unsigned DEPTH = 4;

    logic                 ck = 1'b0;
    logic                 rst;
    logic                 fpu_ready;
    logic                 issue_valid;
    logic                 issue_ready;
    logic                 issue_accept;
    logic [31:0]          issue_instr;
    logic [IDW-1:0]       issue_id;
    logic [2:0][XL-1:0]   issue_rs;
    logic                 commit_valid;
    logic [IDW-1:0]       commit_id;
    logic                 commit_kill;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [31:0]          disp_instr;
    logic [IDW-1:0]       disp_id;
    logic [2:0][XL-1:0]   disp_rs;
    logic [2:0]           occupancy;

    always #5 ck = ~ck;

    fpu_issue_sched #(
        .X_ID_WIDTH  (IDW),
        .XLEN        (XL),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .fpu_ready    (fpu_ready),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_accept (issue_accept),
        .issue_instr  (issue_instr),
        .issue_id     (issue_id),
        .issue_rs     (issue_rs),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_instr   (disp_instr),
        .disp_id      (disp_id),
        .disp_rs      (disp_rs),
        .occupancy    (occupancy)
    );

    // Reference model: an ordered list of in-flight instructions.
    typedef struct {
        logic [IDW-1:0]   id;
        logic [31:0]      instr;
        logic [3*XL-1:0]  rs;
        bit               committed;
        bit               kill;
    } ref_t;

    ref_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every output with what the model says should be visible now.
    task automatic check_outputs();
        bit exp_valid;
        bit exp_ready;
        exp_valid = !rst && q.size() > 0 && q[0].committed && !q[0].kill;
        exp_ready = !rst && fpu_ready && (q.size() < int'(DEPTH));
        check("issue_ready", 128'(issue_ready), 128'(exp_ready));
        check("disp_valid",  128'(disp_valid),  128'(exp_valid));
        check("occupancy",   128'(occupancy),   128'(q.size()));
        if (rst) begin
            check("rst_disp_id",    128'(disp_id),    128'(0));
            check("rst_disp_instr", 128'(disp_instr), 128'(0));
            check("rst_disp_rs",    128'(disp_rs),    128'(0));
        end else if (exp_valid) begin
            check("disp_id",    128'(disp_id),    128'(q[0].id));
            check("disp_instr", 128'(disp_instr), 128'(q[0].instr));
            check("disp_rs",    128'(disp_rs),    128'(q[0].rs));
        end
    endtask

    // Apply one clock edge to the model using the inputs present at the edge.
    task automatic model_update();
        bit   ready;
        bit   do_push;
        bit   do_pop;
        ref_t e;
        if (rst) begin
            q.delete();
        end else begin
            ready   = fpu_ready && (q.size() < int'(DEPTH));
            do_push = issue_valid && ready && issue_accept;
            do_pop  = q.size() > 0 && q[0].committed && (q[0].kill || disp_ready);
            if (commit_valid) begin
                foreach (q[i]) begin
                    if (!q[i].committed && q[i].id == commit_id) begin
                        q[i].committed = 1'b1;
                        q[i].kill      = commit_kill;
                    end
                end
            end
            if (do_push) begin
                e.id        = issue_id;
                e.instr     = issue_instr;
                e.rs        = issue_rs;
                e.committed = commit_valid && (commit_id == issue_id);
                e.kill      = e.committed && commit_kill;
                q.push_back(e);
            end
            if (do_pop) void'(q.pop_front());
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        @(posedge ck);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst          = 1'b0;
        fpu_ready    = 1'b1;
        issue_valid  = 1'b0;
        issue_accept = 1'b0;
        issue_instr  = $urandom;
        issue_id     = '0;
        issue_rs     = {$urandom, $urandom, $urandom};
        commit_valid = 1'b0;
        commit_id    = '0;
        commit_kill  = 1'b0;
        disp_ready   = 1'b1;
    endtask

    task automatic do_issue(input logic [IDW-1:0] id);
        issue_valid  = 1'b1;
        issue_accept = 1'b1;
        issue_id     = id;
        issue_instr  = $urandom;
        issue_rs     = {$urandom, $urandom, $urandom};
        tick();
        idle();
    endtask

    task automatic do_commit(input logic [IDW-1:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge ck);
        #1;
        check("reset_occupancy",   128'(occupancy),   128'(0));
        check("reset_issue_ready", 128'(issue_ready), 128'(0));
        check("reset_disp_valid",  128'(disp_valid),  128'(0));
        idle();

        // Issue, commit, dispatch one cycle after the commit.
        do_issue(4'd3);
        do_commit(4'd3, 1'b0);
        check("s1_disp_valid", 128'(disp_valid), 128'(1));
        check("s1_disp_id",    128'(disp_id),    128'(3));
        check("s1_occ_before", 128'(occupancy),  128'(1));
        tick();
        check("s1_occ_after",  128'(occupancy),  128'(0));

        // Out-of-order commits still dispatch in issue order.
        do_issue(4'd1);
        do_issue(4'd2);
        do_commit(4'd2, 1'b0);
        check("s2_blocked", 128'(disp_valid), 128'(0));
        check("s2_occ",     128'(occupancy),  128'(2));
        do_commit(4'd1, 1'b0);
        check("s2_first_valid", 128'(disp_valid), 128'(1));
        check("s2_first_id",    128'(disp_id),    128'(1));
        tick();
        check("s2_second_valid", 128'(disp_valid), 128'(1));
        check("s2_second_id",    128'(disp_id),    128'(2));
        tick();
        check("s2_drained", 128'(occupancy), 128'(0));

        // Killed entry drains without a dispatch.
        do_issue(4'd5);
        do_commit(4'd5, 1'b1);
        check("s3_no_disp", 128'(disp_valid), 128'(0));
        check("s3_occ_1",   128'(occupancy),  128'(1));
        tick();
        check("s3_occ_0",   128'(occupancy),  128'(0));
        check("s3_no_disp2", 128'(disp_valid), 128'(0));

        // Handshake without accept pushes nothing.
        issue_valid = 1'b1;
        issue_id    = 4'd6;
        tick();
        idle();
        check("noaccept_occ", 128'(occupancy), 128'(0));

        // Fill to depth, refuse a fifth, reopen after one dispatch.
        for (int i = 0; i < int'(DEPTH); i++) do_issue(IDW'(i));
        check("full_ready", 128'(issue_ready), 128'(0));
        check("full_occ",   128'(occupancy),   128'(4));
        issue_valid  = 1'b1;
        issue_accept = 1'b1;
        issue_id     = 4'd7;
        tick();
        idle();
        check("full_no_push", 128'(occupancy), 128'(4));
        do_commit(4'd0, 1'b0);
        check("full_head_valid", 128'(disp_valid),  128'(1));
        check("full_still_busy", 128'(issue_ready), 128'(0));
        tick();
        check("full_reopen", 128'(issue_ready), 128'(1));
        check("full_occ3",   128'(occupancy),   128'(3));
        rst = 1'b1;
        tick();
        idle();

        // fpu_ready low blocks issue.
        fpu_ready    = 1'b0;
        issue_valid  = 1'b1;
        issue_accept = 1'b1;
        issue_id     = 4'd4;
        #1;
        check("fpu_block_ready", 128'(issue_ready), 128'(0));
        tick();
        idle();
        check("fpu_block_occ", 128'(occupancy), 128'(0));

        // Reset discards in-flight work; stale commits are ignored.
        do_issue(4'd8);
        do_issue(4'd9);
        do_issue(4'd10);
        check("s6_occ3", 128'(occupancy), 128'(3));
        rst = 1'b1;
        tick();
        idle();
        check("s6_occ0",   128'(occupancy),  128'(0));
        check("s6_nodisp", 128'(disp_valid), 128'(0));
        do_commit(4'd8, 1'b0);
        check("s6_stale_occ",  128'(occupancy),  128'(0));
        check("s6_stale_disp", 128'(disp_valid), 128'(0));

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst          = ($urandom_range(0, 99) == 0);
            fpu_ready    = ($urandom_range(0, 4) != 0);
            issue_valid  = ($urandom_range(0, 2) != 0);
            issue_accept = ($urandom_range(0, 3) != 0);
            issue_id     = IDW'($urandom_range(0, 7));
            issue_instr  = $urandom;
            issue_rs     = {$urandom, $urandom, $urandom};
            commit_valid = ($urandom_range(0, 1) != 0);
            if (q.size() > 0 && $urandom_range(0, 2) != 0)
                commit_id = q[$urandom_range(0, q.size() - 1)].id;
            else
                commit_id = IDW'($urandom_range(0, 15));
            commit_kill  = ($urandom_range(0, 3) == 0);
            disp_ready   = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
